// File: rtl/bnn_ctrl_pkg.sv
// Shared types and constants for the BNN command controller: state
// encoding, host-visible status codes and default command bytes.
package bnn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IMG_RX = 3'd1,
    RUN    = 3'd2,
    RESULT = 3'd3,
    CLEAR  = 3'd4,
    ERROR  = 3'd5
  } ctrl_state_e;

  // Status nibble reported on status_code and by a readback in IDLE.
  // CLEAR is transient and has no published code; 4'h1 keeps it distinct.
  localparam logic [3:0] STAT_IDLE   = 4'h0;
  localparam logic [3:0] STAT_IMG_RX = 4'h2;
  localparam logic [3:0] STAT_RUN    = 4'h4;
  localparam logic [3:0] STAT_RESULT = 4'h8;
  localparam logic [3:0] STAT_CLEAR  = 4'h1;
  localparam logic [3:0] STAT_ERROR  = 4'hE;

  localparam logic [7:0] CMD_IMG_DEF = 8'hFE;
  localparam logic [7:0] CMD_CLR_DEF = 8'hFD;
  localparam logic [7:0] CMD_RD_DEF  = 8'hFC;

  function automatic logic [3:0] status_of(input ctrl_state_e s);
    logic [3:0] code;
    case (s)
      IDLE:    code = STAT_IDLE;
      IMG_RX:  code = STAT_IMG_RX;
      RUN:     code = STAT_RUN;
      RESULT:  code = STAT_RESULT;
      CLEAR:   code = STAT_CLEAR;
      ERROR:   code = STAT_ERROR;
      default: code = STAT_ERROR;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ctrl_timeout_timer.sv
// Idle-cycle watchdog. Counts enabled cycles since the last restart and
// raises a registered expired flag once TMO_CYCLES cycles have elapsed.
module ctrl_timeout_timer #(
  parameter int               TMO_W      = 20,
  parameter logic [TMO_W-1:0] TMO_CYCLES = {TMO_W{1'b1}}
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  logic [TMO_W-1:0] cnt_r;
  logic             expired_r;

  // Saturating count of enabled cycles; restart always wins over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      expired_r <= 1'b0;
    end else if (restart) begin
      cnt_r     <= '0;
      expired_r <= 1'b0;
    end else if (enable) begin
      if (cnt_r >= (TMO_CYCLES - TMO_W'(1))) begin
        cnt_r     <= TMO_CYCLES;
        expired_r <= 1'b1;
      end else begin
        cnt_r     <= cnt_r + TMO_W'(1);
        expired_r <= 1'b0;
      end
    end else begin
      cnt_r     <= cnt_r;
      expired_r <= expired_r;
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/bnn_cmd_controller.sv
// Command/sequencing controller between the SPI byte receiver, the image
// buffer and the BNN core. Decodes host commands, streams image bytes into
// the buffer with an explicit byte count, starts the core, and returns
// results or status over SPI TX. Every output is registered.
module bnn_cmd_controller
  import bnn_ctrl_pkg::*;
#(
  parameter int               IMG_BYTES  = 113,
  parameter int               ADDR_W     = 7,
  parameter int               RES_W      = 4,
  parameter int               TMO_W      = 20,
  parameter logic [TMO_W-1:0] TMO_CYCLES = 20'hFFFFF,
  parameter bit               CLR_IN_RX  = 1'b0,
  parameter logic [7:0]       CMD_IMG    = CMD_IMG_DEF,
  parameter logic [7:0]       CMD_CLR    = CMD_CLR_DEF,
  parameter logic [7:0]       CMD_RD     = CMD_RD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        spi_rx_data,
  input  logic              spi_rx_valid,
  output logic              byte_taken,
  output logic              rx_enable,
  output logic [7:0]        spi_tx_data,
  output logic              spi_tx_load,
  output logic [3:0]        status_code,
  output logic              buf_clear,
  input  logic              buf_empty,
  input  logic              buf_wr_ready,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [7:0]        buf_wr_data,
  output logic              bnn_start,
  input  logic              result_ready,
  input  logic [RES_W-1:0]  result_out,
  output logic              proto_err
);

  localparam int CNT_W = $clog2(IMG_BYTES + 1);

  ctrl_state_e       state_r;
  ctrl_state_e       state_next_s;

  logic              prev_valid_r;
  logic              pend_valid_r;
  logic [7:0]        pend_data_r;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  count_r;
  logic [RES_W-1:0]  result_r;

  logic              byte_taken_r;
  logic              rx_enable_r;
  logic [7:0]        spi_tx_data_r;
  logic              spi_tx_load_r;
  logic [3:0]        status_code_r;
  logic              buf_clear_r;
  logic              buf_wr_en_r;
  logic [ADDR_W-1:0] buf_wr_addr_r;
  logic [7:0]        buf_wr_data_r;
  logic              bnn_start_r;
  logic              proto_err_r;

  logic              new_byte_s;
  logic              cur_valid_s;
  logic [7:0]        cur_data_s;
  logic              drop_s;
  logic              is_img_s;
  logic              is_clr_s;
  logic              is_rd_s;
  logic              rx_abort_s;
  logic              last_byte_s;
  logic              clear_done_s;
  logic              img_start_s;
  logic              tmo_expired_s;
  logic              tmo_en_s;
  logic              restart_s;

  logic              wr_s;
  logic              tx_load_s;
  logic [7:0]        tx_data_s;
  logic              consume_s;
  logic              set_perr_s;
  logic              latch_res_s;
  logic              accept_s;

  // A byte is "current" either straight off the receiver edge or from the
  // one-entry holding register; the held byte always goes first.
  assign new_byte_s   = spi_rx_valid & ~prev_valid_r;
  assign cur_valid_s  = pend_valid_r | new_byte_s;
  assign cur_data_s   = pend_valid_r ? pend_data_r : spi_rx_data;
  assign drop_s       = new_byte_s & pend_valid_r;
  assign is_img_s     = cur_valid_s & (cur_data_s == CMD_IMG);
  assign is_clr_s     = cur_valid_s & (cur_data_s == CMD_CLR);
  assign is_rd_s      = cur_valid_s & (cur_data_s == CMD_RD);
  assign rx_abort_s   = CLR_IN_RX & is_clr_s;
  assign last_byte_s  = (count_r == CNT_W'(IMG_BYTES - 1));
  assign clear_done_s = (state_r == CLEAR) & buf_empty;
  assign img_start_s  = (state_r == IDLE) & is_img_s;

  // The watchdog only runs while waiting on the host or the core, and is
  // restarted on any state change or accepted byte.
  assign tmo_en_s  = (state_r == IMG_RX) | (state_r == RUN);
  assign restart_s = (state_next_s != state_r) | accept_s;

  ctrl_timeout_timer #(
    .TMO_W      (TMO_W),
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart_s),
    .enable  (tmo_en_s),
    .expired (tmo_expired_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; clear beats result, a write beats timeout, result beats timeout.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (is_img_s) begin
          state_next_s = IMG_RX;
        end else if (is_clr_s) begin
          state_next_s = CLEAR;
        end else begin
          state_next_s = IDLE;
        end
      end
      IMG_RX: begin
        if (rx_abort_s) begin
          state_next_s = CLEAR;
        end else if (cur_valid_s && buf_wr_ready) begin
          state_next_s = last_byte_s ? RUN : IMG_RX;
        end else if (tmo_expired_s) begin
          state_next_s = ERROR;
        end else begin
          state_next_s = IMG_RX;
        end
      end
      RUN: begin
        if (is_clr_s) begin
          state_next_s = CLEAR;
        end else if (result_ready) begin
          state_next_s = RESULT;
        end else if (tmo_expired_s) begin
          state_next_s = ERROR;
        end else begin
          state_next_s = RUN;
        end
      end
      RESULT, ERROR: begin
        if (is_clr_s) begin
          state_next_s = CLEAR;
        end else begin
          state_next_s = state_r;
        end
      end
      CLEAR: begin
        if (buf_empty) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = CLEAR;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Per-state actions: writes, replies, byte consumption and error flags.
  always_comb begin
    wr_s        = 1'b0;
    tx_load_s   = 1'b0;
    tx_data_s   = 8'h00;
    consume_s   = 1'b0;
    set_perr_s  = 1'b0;
    latch_res_s = 1'b0;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        consume_s = cur_valid_s;
        if (is_rd_s) begin
          tx_load_s = 1'b1;
          tx_data_s = {4'h0, status_code_r};
        end else if (cur_valid_s && !is_img_s && !is_clr_s) begin
          set_perr_s = 1'b1;
        end else begin
          set_perr_s = 1'b0;
        end
      end
      IMG_RX: begin
        if (rx_abort_s) begin
          consume_s = 1'b1;
        end else if (cur_valid_s && buf_wr_ready) begin
          wr_s      = 1'b1;
          consume_s = 1'b1;
          accept_s  = 1'b1;
        end else if (cur_valid_s && tmo_expired_s) begin
          consume_s = 1'b1;
        end else begin
          consume_s = 1'b0;
        end
      end
      RUN: begin
        consume_s = cur_valid_s;
        accept_s  = cur_valid_s;
        if (!is_clr_s && result_ready) begin
          latch_res_s = 1'b1;
        end else begin
          latch_res_s = 1'b0;
        end
      end
      RESULT: begin
        consume_s = cur_valid_s;
        if (is_rd_s) begin
          tx_load_s = 1'b1;
          tx_data_s = 8'(result_r);
        end else begin
          tx_load_s = 1'b0;
        end
      end
      ERROR: begin
        consume_s = cur_valid_s;
        if (is_rd_s) begin
          tx_load_s = 1'b1;
          tx_data_s = {4'h0, STAT_ERROR};
        end else begin
          tx_load_s = 1'b0;
        end
      end
      CLEAR:   consume_s = cur_valid_s;
      default: consume_s = cur_valid_s;
    endcase
  end

  // Edge detector and one-entry holding register for bytes that must wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_valid_r <= 1'b1;
      pend_valid_r <= 1'b0;
      pend_data_r  <= 8'h00;
    end else begin
      prev_valid_r <= spi_rx_valid;
      if (consume_s) begin
        pend_valid_r <= 1'b0;
      end else if (new_byte_s && !pend_valid_r) begin
        pend_valid_r <= 1'b1;
        pend_data_r  <= spi_rx_data;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
    end
  end

  // Image address/count, latched result and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= '0;
      count_r     <= '0;
      result_r    <= '0;
      proto_err_r <= 1'b0;
    end else begin
      if (img_start_s || clear_done_s) begin
        addr_r  <= '0;
        count_r <= '0;
      end else if (wr_s) begin
        addr_r  <= addr_r + ADDR_W'(1);
        count_r <= count_r + CNT_W'(1);
      end else begin
        addr_r  <= addr_r;
        count_r <= count_r;
      end
      if (latch_res_s) begin
        result_r <= result_out;
      end else begin
        result_r <= result_r;
      end
      if (clear_done_s) begin
        proto_err_r <= 1'b0;
      end else if (set_perr_s || drop_s) begin
        proto_err_r <= 1'b1;
      end else begin
        proto_err_r <= proto_err_r;
      end
    end
  end

  // Registered copies of every host- and buffer-facing output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_taken_r  <= 1'b0;
      rx_enable_r   <= 1'b0;
      spi_tx_data_r <= 8'h00;
      spi_tx_load_r <= 1'b0;
      status_code_r <= STAT_IDLE;
      buf_clear_r   <= 1'b0;
      buf_wr_en_r   <= 1'b0;
      buf_wr_addr_r <= '0;
      buf_wr_data_r <= 8'h00;
      bnn_start_r   <= 1'b0;
    end else begin
      byte_taken_r  <= new_byte_s;
      rx_enable_r   <= (state_next_s != CLEAR);
      spi_tx_load_r <= tx_load_s;
      spi_tx_data_r <= tx_load_s ? tx_data_s : spi_tx_data_r;
      status_code_r <= status_of(state_next_s);
      buf_clear_r   <= (state_next_s == CLEAR);
      buf_wr_en_r   <= wr_s;
      buf_wr_addr_r <= wr_s ? addr_r : buf_wr_addr_r;
      buf_wr_data_r <= wr_s ? cur_data_s : buf_wr_data_r;
      bnn_start_r   <= (state_next_s == RUN) && (state_r != RUN);
    end
  end

  assign byte_taken  = byte_taken_r;
  assign rx_enable   = rx_enable_r;
  assign spi_tx_data = spi_tx_data_r;
  assign spi_tx_load = spi_tx_load_r;
  assign status_code = status_code_r;
  assign buf_clear   = buf_clear_r;
  assign buf_wr_en   = buf_wr_en_r;
  assign buf_wr_addr = buf_wr_addr_r;
  assign buf_wr_data = buf_wr_data_r;
  assign bnn_start   = bnn_start_r;
  assign proto_err   = proto_err_r;

endmodule

// File: tb/tb_bnn_cmd_controller.sv
// Directed bench for bnn_cmd_controller: a vector table for IDLE command
// handling plus hand-written image, back-pressure, timeout, in-image clear,
// simultaneous-event and reset sequences. Instance A treats 0xFD as data in
// IMG_RX, instance B aborts on it; both see the same stimulus.
module tb_bnn_cmd_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] spi_rx_data;
  logic       spi_rx_valid;
  logic       buf_empty;
  logic       buf_wr_ready;
  logic       result_ready;
  logic [3:0] result_out;

  logic       a_byte_taken, a_rx_enable, a_spi_tx_load, a_buf_clear, a_buf_wr_en, a_bnn_start, a_proto_err;
  logic [7:0] a_spi_tx_data, a_buf_wr_data;
  logic [3:0] a_status_code;
  logic [6:0] a_buf_wr_addr;
  logic       b_byte_taken, b_rx_enable, b_spi_tx_load, b_buf_clear, b_buf_wr_en, b_bnn_start, b_proto_err;
  logic [7:0] b_spi_tx_data, b_buf_wr_data;
  logic [3:0] b_status_code;
  logic [6:0] b_buf_wr_addr;

  int chk;
  int err;
  int wr_idx;
  int b_wr_cnt;
  int start_cnt;
  logic [7:0] img_bytes [0:255];

  bnn_cmd_controller #(
    .IMG_BYTES(113), .ADDR_W(7), .RES_W(4), .TMO_W(20),
    .TMO_CYCLES(20'd100), .CLR_IN_RX(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
    .byte_taken(a_byte_taken), .rx_enable(a_rx_enable), .spi_tx_data(a_spi_tx_data),
    .spi_tx_load(a_spi_tx_load), .status_code(a_status_code), .buf_clear(a_buf_clear),
    .buf_empty(buf_empty), .buf_wr_ready(buf_wr_ready), .buf_wr_en(a_buf_wr_en),
    .buf_wr_addr(a_buf_wr_addr), .buf_wr_data(a_buf_wr_data), .bnn_start(a_bnn_start),
    .result_ready(result_ready), .result_out(result_out), .proto_err(a_proto_err)
  );

  bnn_cmd_controller #(
    .IMG_BYTES(113), .ADDR_W(7), .RES_W(4), .TMO_W(20),
    .TMO_CYCLES(20'd100), .CLR_IN_RX(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
    .byte_taken(b_byte_taken), .rx_enable(b_rx_enable), .spi_tx_data(b_spi_tx_data),
    .spi_tx_load(b_spi_tx_load), .status_code(b_status_code), .buf_clear(b_buf_clear),
    .buf_empty(buf_empty), .buf_wr_ready(buf_wr_ready), .buf_wr_en(b_buf_wr_en),
    .buf_wr_addr(b_buf_wr_addr), .buf_wr_data(b_buf_wr_data), .bnn_start(b_bnn_start),
    .result_ready(result_ready), .result_out(result_out), .proto_err(b_proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic byte_hi(input logic [7:0] b);
    spi_rx_data  = b;
    spi_rx_valid = 1'b1;
    tick();
  endtask

  task automatic byte_lo();
    spi_rx_valid = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_hi(b);
    byte_lo();
  endtask

  // Buffer-write scoreboard for A (address order and data) and write/start counters.
  always @(negedge clk) begin
    if (rst_n && a_buf_wr_en) begin
      check("wr_addr", 32'(a_buf_wr_addr), 32'(wr_idx));
      check("wr_data", 32'(a_buf_wr_data), 32'(img_bytes[wr_idx & 255]));
      wr_idx++;
    end
    if (rst_n && b_buf_wr_en) b_wr_cnt++;
    if (rst_n && a_bnn_start) start_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       chk_stat;
    logic [3:0] stat;
    logic       taken;
    logic       load;
    logic [7:0] txd;
    logic       perr;
    logic       clr;
  } vec_t;

  vec_t vecs [5];
  int   waited;

  initial begin
    vecs[0] = '{8'hFC, 1'b1, 4'h0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'h55, 1'b1, 4'h0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFC, 1'b1, 4'h0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'hFD, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hFC, 1'b1, 4'h0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};

    chk = 0; err = 0; wr_idx = 0; b_wr_cnt = 0; start_cnt = 0;
    for (int i = 0; i < 256; i++) img_bytes[i] = 8'(i);
    clk = 1'b0; rst_n = 1'b0; spi_rx_valid = 1'b1; spi_rx_data = 8'hFE;
    buf_empty = 1'b1; buf_wr_ready = 1'b1; result_ready = 1'b0; result_out = 4'h0;

    // Reset values, with a byte already high at release that must be ignored.
    repeat (3) tick();
    check("rst_status", 32'(a_status_code), 32'h0);
    check("rst_rx_enable", 32'(a_rx_enable), 32'h0);
    check("rst_tx_load", 32'(a_spi_tx_load), 32'h0);
    check("rst_wr_en", 32'(a_buf_wr_en), 32'h0);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      check("stale_byte_taken", 32'(a_byte_taken), 32'h0);
    end
    check("stale_status", 32'(a_status_code), 32'h0);
    check("rx_enable_idle", 32'(a_rx_enable), 32'h1);
    byte_lo();

    // IDLE command table.
    for (int i = 0; i < 5; i++) begin
      byte_hi(vecs[i].data);
      check("vec_taken", 32'(a_byte_taken), 32'(vecs[i].taken));
      check("vec_tx_load", 32'(a_spi_tx_load), 32'(vecs[i].load));
      if (vecs[i].load) check("vec_tx_data", 32'(a_spi_tx_data), 32'(vecs[i].txd));
      if (vecs[i].chk_stat) check("vec_status", 32'(a_status_code), 32'(vecs[i].stat));
      check("vec_proto_err", 32'(a_proto_err), 32'(vecs[i].perr));
      check("vec_buf_clear", 32'(a_buf_clear), 32'(vecs[i].clr));
      byte_lo();
      check("vec_taken_low", 32'(a_byte_taken), 32'h0);
    end

    // Nominal image 0x00..0x70, result 7, readback.
    wr_idx = 0; start_cnt = 0;
    byte_hi(8'hFE);
    check("nom_status_rx", 32'(a_status_code), 32'h2);
    byte_lo();
    for (int i = 0; i < 112; i++) send_byte(8'(i));
    byte_hi(8'h70);
    check("nom_status_run", 32'(a_status_code), 32'h4);
    check("nom_bnn_start", 32'(a_bnn_start), 32'h1);
    byte_lo();
    check("nom_start_low", 32'(a_bnn_start), 32'h0);
    check("nom_wr_count", 32'(wr_idx), 32'd113);
    result_ready = 1'b1; result_out = 4'h7;
    tick();
    result_ready = 1'b0;
    check("nom_status_result", 32'(a_status_code), 32'h8);
    byte_hi(8'hFC);
    check("nom_rd_load", 32'(a_spi_tx_load), 32'h1);
    check("nom_rd_data", 32'(a_spi_tx_data), 32'h07);
    byte_lo();
    byte_hi(8'hFC);
    check("nom_rd_repeat", 32'(a_spi_tx_data), 32'h07);
    check("nom_still_result", 32'(a_status_code), 32'h8);
    byte_lo();
    check("nom_start_count", 32'(start_cnt), 32'd1);

    // Back-pressure: buffer not ready for 10 cycles at byte 5.
    byte_hi(8'hFD);
    check("bp_clear", 32'(a_buf_clear), 32'h1);
    byte_lo();
    check("bp_idle", 32'(a_status_code), 32'h0);
    wr_idx = 0;
    send_byte(8'hFE);
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    buf_wr_ready = 1'b0;
    send_byte(8'h05);
    repeat (8) tick();
    check("bp_no_write", 32'(wr_idx), 32'd5);
    buf_wr_ready = 1'b1;
    tick();
    check("bp_wr_en", 32'(a_buf_wr_en), 32'h1);
    check("bp_wr_addr", 32'(a_buf_wr_addr), 32'd5);
    tick();
    check("bp_one_write", 32'(wr_idx), 32'd6);
    for (int i = 6; i < 112; i++) send_byte(8'(i));
    byte_hi(8'h70);
    check("bp_status_run", 32'(a_status_code), 32'h4);
    byte_lo();
    check("bp_wr_count", 32'(wr_idx), 32'd113);
    check("bp_start_count", 32'(start_cnt), 32'd2);

    // Clear and result_ready together in RUN: clear wins.
    spi_rx_data = 8'hFD; spi_rx_valid = 1'b1; result_ready = 1'b1; result_out = 4'h3;
    tick();
    result_ready = 1'b0;
    check("sim_clear", 32'(a_buf_clear), 32'h1);
    check("sim_not_result", 32'(a_status_code == 4'h8), 32'h0);
    byte_lo();
    check("sim_idle", 32'(a_status_code), 32'h0);

    // Timeout after 3 bytes, with a held byte and a dropped byte.
    buf_empty = 1'b0; wr_idx = 0;
    send_byte(8'hFE);
    for (int i = 0; i < 3; i++) send_byte(8'(i));
    buf_wr_ready = 1'b0;
    send_byte(8'h33);
    send_byte(8'h44);
    check("tmo_drop_perr", 32'(a_proto_err), 32'h1);
    check("tmo_held_no_write", 32'(wr_idx), 32'd3);
    repeat (84) tick();
    check("tmo_not_yet", 32'(a_status_code), 32'h2);
    waited = 0;
    while (a_status_code != 4'hE && waited < 30) begin
      tick();
      waited++;
    end
    check("tmo_error", 32'(a_status_code), 32'hE);
    buf_wr_ready = 1'b1;
    byte_hi(8'hFE);
    check("err_ignores_img", 32'(a_status_code), 32'hE);
    byte_lo();
    byte_hi(8'hFC);
    check("err_rd_load", 32'(a_spi_tx_load), 32'h1);
    check("err_rd_data", 32'(a_spi_tx_data), 32'h0E);
    byte_lo();
    byte_hi(8'hFD);
    check("err_clear", 32'(a_buf_clear), 32'h1);
    byte_lo();
    repeat (4) tick();
    check("clr_held", 32'(a_buf_clear), 32'h1);
    check("clr_rx_off", 32'(a_rx_enable), 32'h0);
    buf_empty = 1'b1;
    tick();
    check("clr_done", 32'(a_buf_clear), 32'h0);
    check("clr_idle", 32'(a_status_code), 32'h0);
    check("clr_perr_cleared", 32'(a_proto_err), 32'h0);

    // 0xFD inside an image: data for A, abort for B.
    wr_idx = 0; b_wr_cnt = 0;
    img_bytes[0] = 8'h10; img_bytes[1] = 8'hFD;
    send_byte(8'hFE);
    send_byte(8'h10);
    byte_hi(8'hFD);
    check("fd_a_written", 32'(a_buf_wr_en), 32'h1);
    check("fd_a_no_clear", 32'(a_buf_clear), 32'h0);
    check("fd_b_clear", 32'(b_buf_clear), 32'h1);
    check("fd_b_no_write", 32'(b_buf_wr_en), 32'h0);
    byte_lo();
    check("fd_b_wr_count", 32'(b_wr_cnt), 32'd1);
    check("fd_a_wr_count", 32'(wr_idx), 32'd2);
    for (int i = 2; i < 40; i++) send_byte(8'(i));
    check("rst_at_40", 32'(wr_idx), 32'd40);

    // Asynchronous reset mid-image.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_status", 32'(a_status_code), 32'h0);
    check("arst_wr_addr", 32'(a_buf_wr_addr), 32'h0);
    check("arst_wr_data", 32'(a_buf_wr_data), 32'h0);
    check("arst_rx_enable", 32'(a_rx_enable), 32'h0);
    check("arst_tx_data", 32'(a_spi_tx_data), 32'h0);
    check("arst_b_status", 32'(b_status_code), 32'h0);
    check("arst_b_perr", 32'(b_proto_err), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    wr_idx = 0;
    img_bytes[0] = 8'h20; img_bytes[1] = 8'h21;
    send_byte(8'hFE);
    send_byte(8'h20);
    send_byte(8'h21);
    check("post_rst_writes", 32'(wr_idx), 32'd2);
    check("post_rst_status", 32'(a_status_code), 32'h2);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/bnn_cmd_controller.md
Name: bnn_cmd_controller

Overview:
- Parametrised command/sequencing controller between the SPI byte receiver, the image buffer and the BNN core of the OCR accelerator.
- Decodes command bytes and counts image bytes explicitly, so it does not rely on a buffer-full flag.
- Stalls on buffer back-pressure, aborts on timeouts, and returns the result or status to the host over SPI TX.

Parameters:
- IMG_BYTES, 113, number of data bytes per image.
- ADDR_W, 7, buffer address width; must satisfy 2**ADDR_W >= IMG_BYTES.
- RES_W, 4, BNN result width; must be <= 8.
- TMO_W, 20, timeout counter width.
- TMO_CYCLES, 20'hFFFFF, idle cycles tolerated in IMG_RX or RUN before an error.
- CLR_IN_RX, 0, mode select. 1: byte 0xFD during IMG_RX aborts the image. 0: every IMG_RX byte is treated as data.
- CMD_IMG, 8'hFE, start-image command. CMD_CLR, 8'hFD, clear command. CMD_RD, 8'hFC, readback command.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- spi_rx_data, in, 8, received byte.
- spi_rx_valid, in, 1, level signal; its rising edge marks a new byte.
- byte_taken, out, 1, one-cycle acknowledge for the byte.
- rx_enable, out, 1, receiver enable.
- spi_tx_data, out, 8, reply byte.
- spi_tx_load, out, 1, one-cycle load strobe for spi_tx_data.
- status_code, out, 4, controller status.
- buf_clear, out, 1, buffer clear request.
- buf_empty, in, 1, buffer is empty.
- buf_wr_ready, in, 1, buffer can accept a write.
- buf_wr_en, out, 1, write strobe.
- buf_wr_addr, out, ADDR_W, write address.
- buf_wr_data, out, 8, write data.
- bnn_start, out, 1, one-cycle BNN start pulse.
- result_ready, in, 1, BNN result valid.
- result_out, in, RES_W, BNN result.
- proto_err, out, 1, sticky flag set by an unknown command.

Behaviour:
- Reset: all outputs are registered and reset to 0, except status_code = IDLE (4'h0). The prev_valid register resets to 1, so a byte already high at reset release is ignored.
- New byte: new = spi_rx_valid & ~prev_valid, evaluated in cycle N.
  - byte_taken pulses in cycle N+1 for every new byte, including ignored ones.
  - A pending byte is held in a 1-entry register. A second edge while a byte is pending is dropped and sets proto_err.
- rx_enable is 1 in every state except CLEAR.
- Status encoding: IDLE=0, IMG_RX=2, RUN=4, RESULT=8, ERROR=E.
- IDLE state:
  - CMD_IMG: go to IMG_RX, clear addr and count.
  - CMD_CLR: go to CLEAR.
  - CMD_RD: spi_tx_data = {4'h0, status_code}, spi_tx_load pulses in N+1.
  - Any other byte: set proto_err and stay in IDLE.
- IMG_RX state:
  - While a byte is pending and buf_wr_ready=1, assert buf_wr_en for one cycle with the current addr and data, then increment addr and count.
  - While buf_wr_ready=0, the byte is held and no write is issued.
  - When count reaches IMG_BYTES, go to RUN. bnn_start pulses on the cycle of entry to RUN.
  - With CLR_IN_RX=1, byte 0xFD is not written and the block goes to CLEAR.
- RUN state:
  - result_ready=1: latch result_out, go to RESULT.
  - CMD_CLR: go to CLEAR. Other bytes are ignored.
- RESULT state:
  - CMD_RD: spi_tx_data = zero-extended latched result, spi_tx_load pulses. May repeat; the state stays RESULT.
  - CMD_CLR: go to CLEAR.
- ERROR state: only CMD_CLR is honoured, and it goes to CLEAR. CMD_RD returns 8'h0E.
- CLEAR state:
  - buf_clear is held high until buf_empty=1. Then go to IDLE with addr=0, count=0 and proto_err cleared.
  - A pending byte is discarded.
- Timeout: the counter resets on state entry and on each accepted byte in IMG_RX or RUN. Reaching TMO_CYCLES in IMG_RX or RUN goes to ERROR. Held back-pressure also counts toward the timeout.
- Priorities:
  - CMD_CLR beats result_ready in the same cycle.
  - A final-byte write beats timeout in the same cycle.
  - result_ready beats timeout.
- Widths: the count is $clog2(IMG_BYTES+1) bits. Addr never wraps, because the block leaves IMG_RX at IMG_BYTES.
- Asynchronous reset mid-operation returns every register to its reset value immediately.

Decomposition:
- bnn_ctrl_pkg holds:
  - the state enum: IDLE, IMG_RX, RUN, RESULT, CLEAR, ERROR;
  - the 4-bit status localparams;
  - the default command codes.
- One sub-module, ctrl_timeout_timer, parameterised by TMO_W and TMO_CYCLES, with ports clk, rst_n, restart, enable, expired.

Test Plan:
- Nominal image: FE, then 113 bytes 0x00..0x70 with buf_wr_ready=1, then result_ready with result_out=4'h7, then FC.
  -> 113 writes at addr 0..112, bnn_start pulses once, status goes 2 -> 4 -> 8, spi_tx_data=8'h07 with spi_tx_load.
- Back-pressure: buf_wr_ready=0 for 10 cycles at byte 5.
  -> no buf_wr_en during the stall, byte 5 is written at addr 5 afterwards, no byte is lost or duplicated.
- Timeout: TMO_CYCLES=100; FE, then 3 bytes, then silence.
  -> status=E after 100 idle cycles, FC returns 8'h0E, FD leads to IDLE once buf_empty is asserted.
- Data 0xFD inside an image:
  -> with CLR_IN_RX=0 it is written as data; with CLR_IN_RX=1, buf_clear rises and no write is issued.
- Simultaneous events in RUN: result_ready and FD in the same cycle.
  -> CLEAR is taken and the result is not latched.
- Protocol and reset:
  - Byte 0x55 in IDLE -> proto_err=1, byte_taken pulses, state stays IDLE.
  - rst_n low mid-IMG_RX at addr 40 -> all outputs return to reset values, and the next image starts at addr 0.
